// File: rtl/gpio_pkg.sv
// Shared definitions for the iomem GPIO peripheral: register word indices,
// default address decode, and the byte-strobe expansion helper.
package gpio_pkg;

  localparam logic [7:0] DEFAULT_ADDR_HI = 8'h03;

  // Word indices (iomem_addr[7:2]) of byte offsets 0x00..0x20.
  localparam logic [5:0] OFF_OUT        = 6'h00;
  localparam logic [5:0] OFF_DIR        = 6'h01;
  localparam logic [5:0] OFF_IN         = 6'h02;
  localparam logic [5:0] OFF_IRQ_EN     = 6'h03;
  localparam logic [5:0] OFF_IRQ_POL    = 6'h04;
  localparam logic [5:0] OFF_IRQ_STATUS = 6'h05;
  localparam logic [5:0] OFF_SET        = 6'h06;
  localparam logic [5:0] OFF_CLR        = 6'h07;
  localparam logic [5:0] OFF_TGL        = 6'h08;

  function automatic logic [31:0] strb_mask(input logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-bit, multi-stage input synchroniser with asynchronous clear.
// Each bit is synchronised independently; no cross-bit coherence is implied.
module gpio_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its predecessor held before this edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the picosoc iomem bus: OUT/DIR registers, synchronised
// input readback, atomic set/clear/toggle, and per-pin edge interrupts.
module iomem_gpio
  import gpio_pkg::*;
#(
  parameter logic [7:0]          ADDR_HI     = DEFAULT_ADDR_HI,
  parameter int                  NUM_GPIO    = 16,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [NUM_GPIO-1:0] RESET_OUT   = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);

  logic                sel;
  logic                wr;
  logic [5:0]          idx;
  logic [31:0]         bmask;
  logic [31:0]         rd_val;
  logic [NUM_GPIO-1:0] wd;
  logic [NUM_GPIO-1:0] s, p, evt, clr;
  logic [NUM_GPIO-1:0] out_q, out_d;
  logic [NUM_GPIO-1:0] dir_q, dir_d;
  logic [NUM_GPIO-1:0] en_q, en_d;
  logic [NUM_GPIO-1:0] pol_q, pol_d;
  logic [NUM_GPIO-1:0] sts_q, sts_d;

  // The !iomem_ready term keeps a held request from being serviced twice.
  assign sel   = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
  assign wr    = sel && (iomem_wstrb != 4'b0000);
  assign idx   = iomem_addr[7:2];
  assign bmask = strb_mask(iomem_wstrb);
  assign wd    = iomem_wdata[NUM_GPIO-1:0] & bmask[NUM_GPIO-1:0];

  gpio_sync #(
    .WIDTH (NUM_GPIO),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .resetn(resetn),
    .d     (gpio_in),
    .q     (s)
  );

  assign evt = (s & ~p & ~pol_q) | (p & ~s & pol_q);

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    en_d  = en_q;
    pol_d = pol_q;
    clr   = '0;
    if (wr) begin
      case (idx)
        OFF_OUT:        out_d = (out_q & ~bmask[NUM_GPIO-1:0]) | wd;
        OFF_DIR:        dir_d = (dir_q & ~bmask[NUM_GPIO-1:0]) | wd;
        OFF_IRQ_EN:     en_d  = (en_q  & ~bmask[NUM_GPIO-1:0]) | wd;
        OFF_IRQ_POL:    pol_d = (pol_q & ~bmask[NUM_GPIO-1:0]) | wd;
        OFF_IRQ_STATUS: clr   = wd;
        OFF_SET:        out_d = out_q | wd;
        OFF_CLR:        out_d = out_q & ~wd;
        OFF_TGL:        out_d = out_q ^ wd;
        default:        ;
      endcase
    end
    // A fresh event outranks a simultaneous write-1-to-clear.
    sts_d = (sts_q & ~clr) | evt;
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      OFF_OUT:        rd_val = 32'(out_q);
      OFF_DIR:        rd_val = 32'(dir_q);
      OFF_IN:         rd_val = 32'(s);
      OFF_IRQ_EN:     rd_val = 32'(en_q);
      OFF_IRQ_POL:    rd_val = 32'(pol_q);
      OFF_IRQ_STATUS: rd_val = 32'(sts_q);
      default:        rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q       <= RESET_OUT;
      dir_q       <= '0;
      en_q        <= '0;
      pol_q       <= '0;
      sts_q       <= '0;
      p           <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      out_q       <= out_d;
      dir_q       <= dir_d;
      en_q        <= en_d;
      pol_q       <= pol_d;
      sts_q       <= sts_d;
      p           <= s;
      iomem_ready <= sel;
      if (sel) begin
        iomem_rdata <= rd_val;
      end
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(sts_q & en_q);

endmodule

// File: tb/tb_iomem_gpio.sv
// Self-checking bench for iomem_gpio: bus reads push expected data to a
// scoreboard that a monitor pops whenever the DUT acknowledges.
module tb_iomem_gpio;

  localparam int          NG   = 16;
  localparam logic [31:0] BASE = 32'h0300_0000;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          iomem_valid = 1'b0;
  logic          iomem_ready;
  logic [3:0]    iomem_wstrb = 4'h0;
  logic [31:0]   iomem_addr = '0;
  logic [31:0]   iomem_wdata = '0;
  logic [31:0]   iomem_rdata;
  logic [NG-1:0] gpio_in = '0;
  logic [NG-1:0] gpio_out;
  logic [NG-1:0] gpio_oe;
  logic          irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  bit          rd_q[$];
  string       tag_q[$];

  logic [31:0] sb_exp;
  bit          sb_rd;
  string       sb_tag;

  iomem_gpio #(
    .ADDR_HI    (8'h03),
    .NUM_GPIO   (NG),
    .SYNC_STAGES(2),
    .RESET_OUT  ('0)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oe    (gpio_oe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every acknowledge must match a queued access.
  always @(negedge clk) begin
    if (resetn && iomem_ready) begin
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        sb_rd  = rd_q.pop_front();
        sb_tag = tag_q.pop_front();
        if (sb_rd) check(sb_tag, iomem_rdata, sb_exp);
      end
    end
  end

  task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wdata, input logic [31:0] exp, input string tag);
    int waited;
    @(negedge clk);
    exp_q.push_back(exp);
    rd_q.push_back(strb == 4'h0);
    tag_q.push_back(tag);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wdata;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!iomem_ready && waited < 8);
    check({tag, ":latency"}, 32'(waited), 32'd1);
    if (!iomem_ready) begin
      sb_exp = exp_q.pop_back();
      sb_rd  = rd_q.pop_back();
      sb_tag = tag_q.pop_back();
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(negedge clk);
    check({tag, ":pulse"}, 32'(iomem_ready), 32'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] strb);
    bus(BASE | 32'(off), strb, d, 32'h0, "wr");
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
    bus(BASE | 32'(off), 4'h0, 32'h0, exp, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;

    // Reset state
    idle(3);
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ready", 32'(iomem_ready), 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;
    rd(8'h00, 32'h0, "rd_out_rst");
    rd(8'h04, 32'h0, "rd_dir_rst");

    // Byte-strobed write of OUT
    wr(8'h00, 32'h0000_A5A5, 4'b0001);
    rd(8'h00, 32'h0000_00A5, "rd_out_lane0");
    check("gpio_out_lane0", 32'(gpio_out), 32'h00A5);

    // Atomic set/clear/toggle
    wr(8'h00, 32'h0000_00F0, 4'hF);
    wr(8'h18, 32'h0000_000F, 4'hF);
    rd(8'h00, 32'h0000_00FF, "rd_after_set");
    wr(8'h1C, 32'h0000_0081, 4'hF);
    rd(8'h00, 32'h0000_007E, "rd_after_clr");
    wr(8'h20, 32'h0000_FFFF, 4'hF);
    rd(8'h00, 32'h0000_FF81, "rd_after_tgl");
    rd(8'h18, 32'h0, "rd_set_reg");
    wr(8'h18, 32'h0000_FF00, 4'b0001);
    rd(8'h00, 32'h0000_FF81, "rd_set_masked");
    wr(8'h20, 32'h0000_0101, 4'b0010);
    rd(8'h00, 32'h0000_FE81, "rd_tgl_lane1");

    // Rising edge interrupt with exact latency
    wr(8'h0C, 32'h0000_0004, 4'hF);
    wr(8'h10, 32'h0, 4'hF);
    gpio_in[2] = 1'b1;
    idle(1); check("rise_irq_c1", 32'(irq), 32'h0);
    idle(1); check("rise_irq_c2", 32'(irq), 32'h0);
    idle(1); check("rise_irq_c3", 32'(irq), 32'h1);
    rd(8'h14, 32'h0000_0004, "rd_sts_rise");
    wr(8'h14, 32'h0000_0004, 4'hF);
    check("w1c_irq", 32'(irq), 32'h0);
    rd(8'h14, 32'h0, "rd_sts_w1c");

    // Falling edge on a masked pin
    wr(8'h0C, 32'h0, 4'hF);
    wr(8'h10, 32'h0000_0020, 4'hF);
    gpio_in[5] = 1'b1;
    idle(5);
    rd(8'h14, 32'h0, "rd_sts_rise_on_fall_pin");
    gpio_in[5] = 1'b0;
    idle(5);
    rd(8'h14, 32'h0000_0020, "rd_sts_fall");
    check("fall_masked_irq", 32'(irq), 32'h0);
    wr(8'h0C, 32'h0000_0020, 4'hF);
    check("fall_unmasked_irq", 32'(irq), 32'h1);
    wr(8'h14, 32'h0000_0020, 4'hF);
    check("fall_w1c_irq", 32'(irq), 32'h0);

    // Event coinciding with W1C of the same bit
    gpio_in[3] = 1'b1;
    idle(5);
    gpio_in[3] = 1'b0;
    idle(5);
    rd(8'h14, 32'h0000_0008, "rd_sts_bit3");
    gpio_in[3] = 1'b1;
    idle(1);
    wr(8'h14, 32'h0000_0008, 4'hF);
    rd(8'h14, 32'h0000_0008, "rd_sts_event_wins");
    wr(8'h14, 32'h0000_0008, 4'hF);
    rd(8'h14, 32'h0, "rd_sts_plain_w1c");

    // One-cycle glitch straddling a clock edge is captured
    gpio_in[1] = 1'b1;
    idle(1);
    gpio_in[1] = 1'b0;
    idle(5);
    rd(8'h14, 32'h0000_0002, "rd_sts_glitch");
    wr(8'h14, 32'h0000_0002, 4'b0010);
    rd(8'h14, 32'h0000_0002, "rd_sts_w1c_wrong_lane");
    wr(8'h14, 32'h0000_0002, 4'b0001);
    rd(8'h14, 32'h0, "rd_sts_w1c_lane0");

    // Address miss
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0000;
    iomem_wstrb = 4'h0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (iomem_ready) cnt++;
    end
    iomem_valid = 1'b0;
    check("miss_no_ready", 32'(cnt), 32'h0);

    // Width, aliasing, read-only and unmapped offsets
    wr(8'h04, 32'hFFFF_FFFF, 4'hF);
    rd(8'h04, 32'h0000_FFFF, "rd_dir_width");
    check("gpio_oe_all", 32'(gpio_oe), 32'h0000_FFFF);
    bus(32'h03AB_CD05, 4'h0, 32'h0, 32'h0000_FFFF, "rd_dir_alias");
    rd(8'h08, 32'(gpio_in), "rd_in");
    wr(8'h08, 32'h0000_FFFF, 4'hF);
    rd(8'h08, 32'(gpio_in), "rd_in_after_wr");
    rd(8'h3C, 32'h0, "rd_unmapped");

    // Reset in the middle of an access
    gpio_in = '0;
    wr(8'h0C, 32'h0000_0001, 4'hF);
    wr(8'h10, 32'h0, 4'hF);
    idle(5);
    gpio_in[0] = 1'b1;
    idle(5);
    gpio_in[0] = 1'b0;
    idle(5);
    check("pre_rst_irq", 32'(irq), 32'h1);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = BASE;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    check("mid_ready_high", 32'(iomem_ready), 32'h1);
    resetn = 1'b0;
    #1;
    check("mid_ready_drop", 32'(iomem_ready), 32'h0);
    check("mid_gpio_out", 32'(gpio_out), 32'h0);
    check("mid_gpio_oe", 32'(gpio_oe), 32'h0);
    check("mid_irq", 32'(irq), 32'h0);
    check("mid_rdata", iomem_rdata, 32'h0);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    idle(2);
    resetn = 1'b1;
    rd(8'h00, 32'h0, "rd_out_post_rst");
    rd(8'h04, 32'h0, "rd_dir_post_rst");
    rd(8'h0C, 32'h0, "rd_en_post_rst");
    rd(8'h14, 32'h0, "rd_sts_post_rst");

    idle(2);
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
